// File: rtl/alu_pkg.sv
// alu_pkg: ALU mode codes and arbiter FSM states shared by alu and alu_arbiter
package alu_pkg;
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    SLT = 4'd5,
    SLL = 4'd6,
    SRL = 4'd7,
    SRA = 4'd8
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_e;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU (op1, op2, ctrl -> aluout, zero); undecoded ctrl returns op1 with zero=0
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] op1,
  input  logic [DATA_WIDTH-1:0] op2,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0] aluout,
  output logic                  zero
);
  logic hit;
  always_comb begin
    aluout = op1;
    hit    = 1'b1;
    case (ctrl)
      CTRL_WIDTH'(ADD): aluout = op1 + op2;
      CTRL_WIDTH'(SUB): aluout = op1 - op2;
      CTRL_WIDTH'(AND): aluout = op1 & op2;
      CTRL_WIDTH'(OR):  aluout = op1 | op2;
      CTRL_WIDTH'(SLT): aluout = {{(DATA_WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      CTRL_WIDTH'(SLL): aluout = op1 << op2;
      CTRL_WIDTH'(SRL): aluout = op1 >> op2;
      CTRL_WIDTH'(SRA): aluout = $signed(op1) >>> op2;
      default:          hit    = 1'b0;
    endcase
    zero = hit && (aluout == '0);
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: time-shares one alu between two requesters (req_* in, resp_* out, busy) via IDLE/EXEC/RESP
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_op1,
  input  logic [2*DATA_WIDTH-1:0] req_op2,
  input  logic [2*CTRL_WIDTH-1:0] req_ctrl,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_result,
  output logic                    resp_zero,
  output logic                    busy
);
  arb_state_e            state;
  logic                  owner, last_grant, gnt, zero;
  logic [DATA_WIDTH-1:0] op1_q, op2_q, aluout;
  logic [CTRL_WIDTH-1:0] ctrl_q;
  assign gnt        = &req_valid ? ~last_grant : req_valid[1];
  assign req_ready  = (state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = state != IDLE;
  alu #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_alu (
    .op1(op1_q), .op2(op2_q), .ctrl(ctrl_q), .aluout(aluout), .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          op1_q      <= gnt ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
          op2_q      <= gnt ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];
          ctrl_q     <= gnt ? req_ctrl[2*CTRL_WIDTH-1:CTRL_WIDTH] : req_ctrl[CTRL_WIDTH-1:0];
          owner      <= gnt;
          last_grant <= gnt;
          state      <= EXEC;
        end
        EXEC: begin
          resp_result <= aluout;
          resp_zero   <= zero;
          state       <= RESP;
        end
        RESP: if (resp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req_valid = '0, resp_ready = '0;
  logic [63:0] req_op1 = '0, req_op2 = '0;
  logic [7:0]  req_ctrl = '0;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_result;
  logic        resp_zero, busy;
  int          cmps = 0, errs = 0, lg = 1, g = 0;
  alu_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    logic [31:0] r;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: r = (b > 31) ? 32'd0 : a << b;
      4'd7: r = (b > 31) ? 32'd0 : a >> b;
      4'd8: r = (b > 31) ? {32{a[31]}} : 32'($signed(a) >>> b);
      default: return {1'b0, a};
    endcase
    return {r == 32'd0, r};
  endfunction
  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_op1[i*32 +: 32] = a;
    req_op2[i*32 +: 32] = b;
    req_ctrl[i*4 +: 4]  = c;
  endtask
  task automatic rand_req(input int i);
    logic [31:0] a;
    logic [3:0]  c;
    a = $urandom;
    c = 4'($urandom_range(0, 15));
    if (c >= 6 && c <= 8) set_req(i, a, $urandom_range(0, 40), c);
    else if ($urandom_range(0, 3) == 0) set_req(i, a, a, c);
    else set_req(i, a, $urandom, c);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_resp_valid"}, resp_valid, 2'b00);
    chk({tag, "_resp_result"}, resp_result, 32'd0);
    chk({tag, "_resp_zero"}, resp_zero, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask
  task automatic serve(input int stall, output int gw);
    logic [32:0] e;
    logic [1:0]  oh;
    #1;
    gw = (req_valid == 2'b11) ? 1 - lg : (req_valid[1] ? 1 : 0);
    oh = gw ? 2'b10 : 2'b01;
    chk("grant_ready", req_ready, oh);
    e = ref_alu(req_op1[gw*32 +: 32], req_op2[gw*32 +: 32], req_ctrl[gw*4 +: 4]);
    tick;
    lg = gw;
    req_valid[gw] = 1'b0;
    req_op1[gw*32 +: 32] = $urandom;
    req_ctrl[gw*4 +: 4] = 4'($urandom);
    chk("exec_busy", busy, 1'b1);
    chk("exec_req_ready", req_ready, 2'b00);
    chk("exec_resp_valid", resp_valid, 2'b00);
    tick;
    chk("resp_valid", resp_valid, oh);
    chk("resp_result", resp_result, e[31:0]);
    chk("resp_zero", resp_zero, e[32]);
    for (int k = 0; k < stall; k++) begin
      resp_ready = '0;
      resp_ready[1-gw] = 1'($urandom);
      tick;
      chk("hold_resp_valid", resp_valid, oh);
      chk("hold_result", resp_result, e[31:0]);
      chk("hold_zero", resp_zero, e[32]);
      chk("hold_req_ready", req_ready, 2'b00);
      chk("hold_busy", busy, 1'b1);
    end
    resp_ready = '0;
    resp_ready[gw] = 1'b1;
    tick;
    resp_ready = '0;
    chk("done_resp_valid", resp_valid, 2'b00);
    chk("done_busy", busy, 1'b0);
  endtask
  initial begin
    tick;
    tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    set_req(0, 32'd5, 32'd7, 4'd0);
    req_valid = 2'b01;
    #1;
    chk("add_ready_same_cycle", req_ready, 2'b01);
    serve(0, g);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    lg = 1;
    set_req(0, 32'd3, 32'd3, 4'd1);
    set_req(1, 32'd1, 32'd2, 4'd0);
    req_valid = 2'b11;
    serve(1, g);
    chk("tie_first", g, 0);
    serve(0, g);
    chk("tie_second", g, 1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++) if (!req_valid[i]) rand_req(i);
      req_valid = 2'b11;
      serve(0, g);
      chk("alternate", g, k % 2);
    end
    req_valid = 2'b00;
    set_req(1, 32'h0000_1234, 32'h0000_1234, 4'd1);
    req_valid = 2'b10;
    serve(5, g);
    set_req(1, 32'hF0, 32'h0F, 4'd3);
    req_valid = 2'b10;
    tick;
    req_valid = 2'b00;
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    resp_ready = 2'b11;
    tick;
    rst = 1'b0;
    resp_ready = 2'b00;
    lg = 1;
    check_reset_outputs("rst_exec");
    tick;
    check_reset_outputs("rst_after");
    set_req(0, 32'd5, 32'd7, 4'd0);
    req_valid = 2'b01;
    serve(0, g);
    set_req(1, 32'hDEADBEEF, 32'h1, 4'hF);
    req_valid = 2'b10;
    serve(4, g);
    for (int k = 0; k < 25; k++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) if (m[i] && !req_valid[i]) rand_req(i);
      req_valid = req_valid | m;
      serve($urandom_range(0, 3), g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
